// File: rtl/imem_port_arbiter_if.sv
// Port bundle linking the instruction-SRAM arbiter to the fetch stage, the program loader and the SRAM.
// The master modport is the arbiter's view; slave is the view of everything around it.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic                  fetch_req;
  logic [ADDR_W-2:0]     fetch_pc;
  logic                  fetch_ack;
  logic [2*DATA_W-1:0]   fetch_instr;
  logic                  load_valid;
  logic [ADDR_W-1:0]     load_addr;
  logic [DATA_W-1:0]     load_data;
  logic                  load_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  busy;

  modport master (
    input  fetch_req, fetch_pc, load_valid, load_addr, load_data, mem_rdata,
    output fetch_ack, fetch_instr, load_ready, mem_addr, mem_we, mem_wdata, busy
  );

  modport slave (
    output fetch_req, fetch_pc, load_valid, load_addr, load_data, mem_rdata,
    input  fetch_ack, fetch_instr, load_ready, mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Owns the single instruction-SRAM port: round-robin between loader byte writes and
// two-read 16-bit big-endian instruction fetches; ack 3 cycles after a fetch grant.
module imem_port_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  imem_port_arbiter_if.master bus
);
  localparam int PC_W = ADDR_W - 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] RD_HI = 2'd2;
  localparam logic [1:0] RD_LO = 2'd3;

  localparam logic GNT_LOAD  = 1'b0;
  localparam logic GNT_FETCH = 1'b1;

  logic [1:0]          state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic                ack_q, ack_d;
  logic [2*DATA_W-1:0] instr_q, instr_d;
  logic                grant_load, grant_fetch;

  // On a tie the side that did not win last time gets the port.
  always_comb begin
    grant_load  = 1'b0;
    grant_fetch = 1'b0;
    if (state_q == IDLE) begin
      if (bus.load_valid && bus.fetch_req) begin
        grant_load  = (last_grant_q == GNT_FETCH);
        grant_fetch = (last_grant_q == GNT_LOAD);
      end else begin
        grant_load  = bus.load_valid;
        grant_fetch = bus.fetch_req;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    pc_d         = pc_q;
    hi_d         = hi_q;
    ack_d        = 1'b0;
    instr_d      = instr_q;
    case (state_q)
      IDLE: begin
        if (grant_load) begin
          waddr_d      = bus.load_addr;
          wdata_d      = bus.load_data;
          last_grant_d = GNT_LOAD;
          state_d      = WRITE;
        end else if (grant_fetch) begin
          pc_d         = bus.fetch_pc;
          last_grant_d = GNT_FETCH;
          state_d      = RD_HI;
        end
      end
      WRITE: state_d = IDLE;
      RD_HI: begin
        hi_d    = bus.mem_rdata;
        state_d = RD_LO;
      end
      RD_LO: begin
        instr_d = {hi_q, bus.mem_rdata};
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_FETCH;
      waddr_q      <= '0;
      wdata_q      <= '0;
      pc_q         <= '0;
      hi_q         <= '0;
      ack_q        <= 1'b0;
      instr_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      pc_q         <= pc_d;
      hi_q         <= hi_d;
      ack_q        <= ack_d;
      instr_q      <= instr_d;
    end
  end

  // SRAM controls decode straight from state so an async reset kills a write at once.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    case (state_q)
      WRITE: begin
        bus.mem_addr  = waddr_q;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = wdata_q;
      end
      RD_HI:   bus.mem_addr = {pc_q, 1'b0};
      RD_LO:   bus.mem_addr = {pc_q, 1'b1};
      default: bus.mem_addr = '0;
    endcase
  end

  assign bus.load_ready  = (state_q == IDLE) && !(bus.load_valid && grant_fetch);
  assign bus.fetch_ack   = ack_q;
  assign bus.fetch_instr = instr_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: SRAM model, byte-array reference memory and an
// expected-instruction queue drained by a negedge monitor.
module tb_imem_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] sram    [512];
  logic [7:0] ref_mem [512];
  logic       pl_we = 1'b0;
  logic [8:0] pl_addr = '0;
  logic [7:0] pl_dat = '0;

  assign bus.mem_rdata = sram[bus.mem_addr];
  always @(posedge clk) begin
    if (pl_we) sram[pl_addr] <= pl_dat;
    else if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q [$];
  int          req_q [$];
  logic [7:0]  f_pc_q [$];
  logic [15:0] f_exp_q [$];
  int lat_lo = 3;
  int lat_hi = 3;
  logic [8:0] last_ld_addr = '0;
  logic [7:0] last_ld_dat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  function automatic logic [15:0] ref_instr(input logic [7:0] p);
    return {ref_mem[{p, 1'b0}], ref_mem[{p, 1'b1}]};
  endfunction

  task automatic monitor();
    logic [15:0] last_instr;
    logic        prev_rd;
    last_instr = '0;
    prev_rd    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_instr = '0;
        prev_rd    = 1'b0;
      end else begin
        if (bus.fetch_ack) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_ack: fetch_ack=1, required 0 (nothing outstanding, t=%0t)", $time);
          end else begin
            check("fetch_instr", 32'(bus.fetch_instr), 32'(exp_q.pop_front()));
            check_range("fetch_latency", cyc - req_q.pop_front(), lat_lo, lat_hi);
          end
          last_instr = bus.fetch_instr;
        end else begin
          check("instr_hold", 32'(bus.fetch_instr), 32'(last_instr));
        end
        if (!bus.busy) begin
          check("idle_mem_bus", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'(0));
          prev_rd = 1'b0;
        end else if (bus.mem_we) begin
          check("write_bus", 32'({bus.mem_addr, bus.mem_wdata}), 32'({last_ld_addr, last_ld_dat}));
          prev_rd = 1'b0;
        end else begin
          check("read_addr", 32'(bus.mem_addr), 32'({bus.fetch_pc, prev_rd}));
          prev_rd = ~prev_rd;
        end
      end
    end
  endtask

  task automatic load_byte(input logic [8:0] a, input logic [7:0] d);
    int w;
    w = 0;
    @(posedge clk); #1;
    bus.load_valid = 1'b1;
    bus.load_addr  = a;
    bus.load_data  = d;
    forever begin
      @(negedge clk);
      if (bus.load_ready) begin
        ref_mem[a]   = d;
        last_ld_addr = a;
        last_ld_dat  = d;
        break;
      end
      w++;
      if (w > 40) break;
    end
    check_range("load_wait", w, 0, 3);
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
  endtask

  // Each fetch is acked before the next is issued; gap 0 re-requests in the ack cycle.
  task automatic run_fetches(input int max_gap);
    int w;
    int g;
    @(posedge clk); #1;
    while (f_pc_q.size() > 0) begin
      bus.fetch_pc  = f_pc_q.pop_front();
      bus.fetch_req = 1'b1;
      exp_q.push_back(f_exp_q.pop_front());
      req_q.push_back(cyc);
      w = 0;
      do begin
        @(posedge clk); #1;
        w++;
      end while (!bus.fetch_ack && w < 40);
      check_range("fetch_ack_wait", w, 3, 5);
      g = int'($urandom_range(max_gap, 0));
      if (f_pc_q.size() == 0 || g > 0) begin
        bus.fetch_req = 1'b0;
        repeat (g) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic queue_fetch(input logic [7:0] p, input logic [15:0] e);
    f_pc_q.push_back(p);
    f_exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] p;
    logic       took;
    bus.fetch_req  = 1'b0;
    bus.fetch_pc   = '0;
    bus.load_valid = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = '0;
    fork monitor(); join_none

    for (int i = 0; i < 512; i++) begin
      @(posedge clk); #1;
      pl_we = 1'b1;
      pl_addr = 9'(i);
      pl_dat = 8'($urandom);
      ref_mem[i] = pl_dat;
    end
    @(posedge clk); #1;
    pl_we = 1'b0;

    check("rst_ack", 32'(bus.fetch_ack), 32'(0));
    check("rst_instr", 32'(bus.fetch_instr), 32'(0));
    check("rst_mem_bus", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_load_ready", 32'(bus.load_ready), 32'(1));

    // Contention from reset: loader wins first, then strict alternation.
    bus.load_valid = 1'b1;
    bus.load_addr  = 9'h100 | 9'($urandom_range(255, 0));
    bus.load_data  = 8'($urandom);
    bus.fetch_req  = 1'b1;
    bus.fetch_pc   = 8'($urandom_range(127, 0));
    lat_lo = 5; lat_hi = 5;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(ref_instr(bus.fetch_pc));
    req_q.push_back(cyc);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("cont_load_ready", 32'(bus.load_ready), 32'(k % 5 == 0));
      check("cont_mem_we", 32'(bus.mem_we), 32'(k % 5 == 1));
      check("cont_fetch_ack", 32'(bus.fetch_ack), 32'(k % 5 == 0 && k > 0));
      if (k == 15) begin
        #1;
        bus.load_valid = 1'b0;
        bus.fetch_req  = 1'b0;
      end else begin
        took = 1'b0;
        if (bus.load_valid && bus.load_ready) begin
          ref_mem[bus.load_addr] = bus.load_data;
          last_ld_addr = bus.load_addr;
          last_ld_dat  = bus.load_data;
          took = 1'b1;
        end
        if (bus.fetch_ack) begin
          exp_q.push_back(ref_instr(bus.fetch_pc));
          req_q.push_back(cyc);
        end
        @(posedge clk); #1;
        if (took) begin
          bus.load_addr = 9'h100 | 9'($urandom_range(255, 0));
          bus.load_data = 8'($urandom);
        end
      end
    end
    repeat (3) @(negedge clk);
    lat_lo = 3; lat_hi = 3;

    load_byte(9'h014, 8'h12);
    load_byte(9'h015, 8'h34);
    queue_fetch(8'h0A, 16'h1234);
    run_fetches(0);

    load_byte(9'h1FE, 8'hAB);
    load_byte(9'h1FF, 8'hCD);
    queue_fetch(8'hFF, 16'hABCD);
    queue_fetch(8'h00, ref_instr(8'h00));
    run_fetches(0);

    queue_fetch(8'h05, ref_instr(8'h05));
    run_fetches(0);
    load_byte(9'h00A, 8'h77);
    queue_fetch(8'h05, {8'h77, ref_mem[9'h00B]});
    run_fetches(0);

    for (int i = 0; i < 12; i++) begin
      p = 8'($urandom);
      queue_fetch(p, ref_instr(p));
    end
    run_fetches(0);

    // Concurrent traffic: fetches stay in the low half, loads go to the high half.
    for (int i = 0; i < 30; i++) begin
      p = 8'($urandom_range(127, 0));
      queue_fetch(p, ref_instr(p));
    end
    lat_lo = 3; lat_hi = 5;
    fork
      run_fetches(2);
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(2, 0)) @(posedge clk);
          load_byte(9'h100 | 9'($urandom_range(255, 0)), 8'($urandom));
        end
      end
    join
    repeat (3) @(negedge clk);
    lat_lo = 3; lat_hi = 3;

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        load_byte(9'($urandom), 8'($urandom));
      end else begin
        p = 8'($urandom);
        queue_fetch(p, ref_instr(p));
        run_fetches(0);
      end
    end

    // Reset in the middle of a write: the target byte must keep its old value.
    @(posedge clk); #1;
    bus.load_valid = 1'b1;
    bus.load_addr  = 9'h0AA;
    bus.load_data  = ~ref_mem[9'h0AA];
    @(negedge clk);
    check("rst_wr_ready", 32'(bus.load_ready), 32'(1));
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    check("rst_wr_we_before", 32'(bus.mem_we), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    check("rst_wr_mem_bus", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'(0));
    check("rst_wr_busy", 32'(bus.busy), 32'(0));
    check("rst_wr_ack", 32'(bus.fetch_ack), 32'(0));
    check("rst_wr_instr", 32'(bus.fetch_instr), 32'(0));
    check("rst_wr_load_ready", 32'(bus.load_ready), 32'(1));
    @(negedge clk); #1;
    rst_n = 1'b1;
    queue_fetch(8'h55, ref_instr(8'h55));
    run_fetches(0);

    // Reset during a fetch: no ack may ever follow.
    @(posedge clk); #1;
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 8'h33;
    @(posedge clk); #1;
    check("rst_rd_busy_before", 32'(bus.busy), 32'(1));
    rst_n = 1'b0;
    bus.fetch_req = 1'b0;
    #1;
    check("rst_rd_busy", 32'(bus.busy), 32'(0));
    check("rst_rd_mem_addr", 32'(bus.mem_addr), 32'(0));
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_rd_no_ack", 32'(bus.fetch_ack), 32'(0));
    end

    repeat (4) @(posedge clk);
    check("drain", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
